bridge_data_fifo: RTL and testbench

Synchronous first-word-fall-through data FIFO between the AXI-side reader and the AXI-side writer in the AXI2APB bridge. It absorbs data beats that the reader pushes with its data-write strobe. It holds them until the APB engine or the writer side pops them with the data-read strobe. It reports occupancy and watermark status so the engine can throttle AXI handshakes. It also carries a per-beat last flag so that burst boundaries survive buffering.

---
 rtl/bridge_data_fifo.sv | 113 +++++++++++
 tb/tb_bridge_data_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bridge_data_fifo.sv
// First-word-fall-through data FIFO between the AXI reader and writer of the AXI2APB bridge.
// Each entry carries a data beat plus its burst-last flag; occupancy and sticky error status are registered.
module bridge_data_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_last,
  output logic                    full,
  output logic                    almost_full,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [DATA_WIDTH:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_pop_empty;
  logic [DATA_WIDTH:0] w_head;

  // Count moves only when exactly one of push/pop happens, so it stays within 0..DEPTH.
  function automatic logic [CW-1:0] count_next(input logic [CW-1:0] cur,
                                               input logic push,
                                               input logic pop);
    logic [CW-1:0] nxt;
    nxt = cur;
    if (push && !pop)
      nxt = cur + CW'(1);
    else if (pop && !push)
      nxt = cur - CW'(1);
    return nxt;
  endfunction

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  assign w_pop       = rd_en && !w_empty && !flush;
  assign w_push      = wr_en && (!w_full || (rd_en && !w_empty)) && !flush;
  assign w_drop      = wr_en && w_full && !rd_en && !flush;
  assign w_pop_empty = rd_en && w_empty && !flush;

  // Array is reset so the fall-through head is never X out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_last, wr_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= count_next(r_count, w_push, w_pop);
      if (w_drop)
        r_overflow <= 1'b1;
      if (w_pop_empty)
        r_underflow <= 1'b1;
    end
  end

  // Status is decoded from registered state only; no path from the strobes.
  assign full        = w_full;
  assign almost_full = (r_count >= AF_C);
  assign empty       = w_empty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

  assign w_head  = r_mem[r_rd_ptr];
  assign rd_data = w_head[DATA_WIDTH-1:0];
  assign rd_last = w_head[DATA_WIDTH];

endmodule

// File: tb/tb_bridge_data_fifo.sv
// Scoreboard bench for bridge_data_fifo: stimulus queues expected beats, a negedge monitor checks pops.
module tb_bridge_data_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          full;
  logic          almost_full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  bridge_data_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_last(rd_last),
    .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW:0] exp_q[$];
  logic [DW:0] mon_e;
  int          m_cnt;
  logic        m_ovf;
  logic        m_udf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".count"},       64'(count),       64'(m_cnt));
    chk({tag, ".empty"},       64'(empty),       64'(m_cnt == 0));
    chk({tag, ".full"},        64'(full),        64'(m_cnt == DEPTH));
    chk({tag, ".almost_full"}, 64'(almost_full), 64'(m_cnt >= AF));
    chk({tag, ".overflow"},    64'(overflow),    64'(m_ovf));
    chk({tag, ".underflow"},   64'(underflow),   64'(m_udf));
  endtask

  // One clock of stimulus; the reference model decides acceptance independently of the DUT.
  task automatic cyc(input string tag, input logic f, input logic w,
                     input logic [DW-1:0] d, input logic l, input logic r);
    bit push;
    bit pop;
    flush   = f;
    wr_en   = w;
    wr_data = d;
    wr_last = l;
    rd_en   = r;
    pop  = r && (m_cnt > 0);
    push = w && ((m_cnt < DEPTH) || pop);
    if (f) begin
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && !push) m_ovf = 1'b1;
      if (r && m_cnt == 0) m_udf = 1'b1;
      if (push) exp_q.push_back({l, d});
      m_cnt = m_cnt + int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_status(tag);
  endtask

  // Monitor: every accepted pop must present the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && !flush && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected none at %0t", rd_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", 64'(rd_data), 64'(mon_e[DW-1:0]));
        chk("rd_last", 64'(rd_last), 64'(mon_e[DW]));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; rd_en = 1'b0;
    m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset");
    chk("reset.rd_data", 64'(rd_data), 64'h0);
    chk("reset.rd_last", 64'(rd_last), 64'h0);
    rst = 1'b0;

    // Fill to full, last flag on every fourth beat.
    for (int i = 0; i < DEPTH; i++)
      cyc("fill", 1'b0, 1'b1, DW'(32'h1000 + i), (i % 4) == 3, 1'b0);
    cyc("overflow", 1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0);
    cyc("ovf_sticky", 1'b0, 1'b0, '0, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++)
      cyc("drain", 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc("underflow", 1'b0, 1'b0, '0, 1'b0, 1'b1);

    cyc("flush_clr", 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      cyc("refill", 1'b0, 1'b1, DW'(32'h2000 + i), (i % 3) == 0, 1'b0);
    cyc("pushpop_full", 1'b0, 1'b1, 32'hA5, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      cyc("drain2", 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc("pushpop_empty", 1'b0, 1'b1, 32'h5A, 1'b0, 1'b1);

    // Bring count to 3 then stream with simultaneous push and pop.
    cyc("flush2", 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("prime", 1'b0, 1'b1, DW'(32'h3000 + i), 1'b0, 1'b0);
    for (int i = 3; i < 103; i++)
      cyc("stream", 1'b0, 1'b1, DW'(32'h3000 + i), (i % 8) == 7, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc("stream_drain", 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Flush at count 5 with a concurrent push that must be discarded.
    for (int i = 0; i < 5; i++)
      cyc("pre_flush", 1'b0, 1'b1, DW'(32'h4000 + i), 1'b0, 1'b0);
    cyc("flush_push", 1'b1, 1'b1, 32'hBEEF, 1'b0, 1'b0);
    cyc("post_flush", 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset pulse between edges at count 7.
    for (int i = 0; i < 7; i++)
      cyc("pre_rst", 1'b0, 1'b1, DW'(32'h5000 + i), 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    chk_status("async_rst");
    chk("async_rst.rd_data", 64'(rd_data), 64'h0);
    #3;
    rst = 1'b0;
    cyc("after_rst_push", 1'b0, 1'b1, 32'h6000, 1'b1, 1'b0);
    cyc("after_rst_pop", 1'b0, 1'b0, '0, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
